// File: rtl/aes_pkg.sv
// Shared AES constants: block width, round counts and the round-sequencer state encoding.
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned AES_NR128 = 10;
    localparam int unsigned AES_NR192 = 12;
    localparam int unsigned AES_NR256 = 14;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        FST  = 3'd2,
        MID  = 3'd3,
        LST  = 3'd4,
        OUT  = 3'd5
    } aesState_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES round datapath: latches one block, walks init/first/mid/last, presents the result.
// Optional block-count output oBlkCnt is built when AES_ROUND_CTRL_BLKCNT_EN is defined.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES_NR128,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iInValid,
    output logic                 oInReady,
    input  logic [AES_BLK_W-1:0] iPlainText,
    input  logic [AES_BLK_W-1:0] iAesKey,
    output logic [AES_BLK_W-1:0] oPlainText,
    output logic [AES_BLK_W-1:0] oAesKey,
    output logic                 oInitRoundFlag,
    output logic                 oFstRoundFlag,
    output logic                 oMidRoundFlag,
    output logic                 oLstRoundFlag,
    input  logic [AES_BLK_W-1:0] iRoundCpText,
    output logic                 oOutValid,
    input  logic                 iOutReady,
    output logic [AES_BLK_W-1:0] oCpText,
`ifdef AES_ROUND_CTRL_BLKCNT_EN
    output logic [15:0]          oBlkCnt,
`endif
    output logic                 oBusy
);

    aesState_e        state;
    aesState_e        nextState;
    logic [CNT_W-1:0] roundCnt;
    logic             loadBlk;
    logic             cntClr;
    logic             cntInc;

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and flag decode; flags come straight from the state register
    always_comb begin
        nextState      = state;
        loadBlk        = 1'b0;
        cntClr         = 1'b0;
        cntInc         = 1'b0;
        oInReady       = 1'b0;
        oInitRoundFlag = 1'b0;
        oFstRoundFlag  = 1'b0;
        oMidRoundFlag  = 1'b0;
        oLstRoundFlag  = 1'b0;
        oOutValid      = 1'b0;
        oBusy          = 1'b1;
        oCpText        = '0;
        case (state)
            IDLE: begin
                oBusy    = 1'b0;
                oInReady = 1'b1;
                if (iInValid) begin
                    loadBlk   = 1'b1;
                    nextState = INIT;
                end
            end
            INIT: begin
                oInitRoundFlag = 1'b1;
                nextState      = FST;
            end
            FST: begin
                oFstRoundFlag = 1'b1;
                cntClr        = 1'b1;
                nextState     = MID;
            end
            MID: begin
                oMidRoundFlag = 1'b1;
                cntInc        = 1'b1;
                if (roundCnt == CNT_W'(NR - 3)) begin
                    nextState = LST;
                end
            end
            LST: begin
                oLstRoundFlag = 1'b1;
                nextState     = OUT;
            end
            OUT: begin
                oOutValid = 1'b1;
                oCpText   = iRoundCpText;
                oInReady  = iOutReady;
                // Accepting a new block while draining avoids an IDLE bubble
                if (iOutReady) begin
                    if (iInValid) begin
                        loadBlk   = 1'b1;
                        nextState = INIT;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: begin
                oBusy     = 1'b0;
                nextState = IDLE;
            end
        endcase
    end

    // Round counter, cleared in the first round and advanced through the middle rounds
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            roundCnt <= '0;
        end else if (cntClr) begin
            roundCnt <= '0;
        end else if (cntInc) begin
            roundCnt <= roundCnt + CNT_W'(1);
        end
    end

    // Plaintext and key held for the whole operation
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oPlainText <= '0;
            oAesKey    <= '0;
        end else if (loadBlk) begin
            oPlainText <= iPlainText;
            oAesKey    <= iAesKey;
        end
    end

`ifdef AES_ROUND_CTRL_BLKCNT_EN
    logic [15:0] blkCnt;

    // Saturating count of delivered ciphertext blocks
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            blkCnt <= '0;
        end else if (oOutValid && iOutReady && (blkCnt != 16'hFFFF)) begin
            blkCnt <= blkCnt + 16'd1;
        end
    end

    assign oBlkCnt = blkCnt;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES-128 round function driven by the round flags.
module tb_aes_round_ctrl;

    logic         iClk;
    logic         iRst;
    logic         iInValid;
    logic         oInReady;
    logic [127:0] iPlainText;
    logic [127:0] iAesKey;
    logic [127:0] oPlainText;
    logic [127:0] oAesKey;
    logic         oInitRoundFlag;
    logic         oFstRoundFlag;
    logic         oMidRoundFlag;
    logic         oLstRoundFlag;
    logic [127:0] iRoundCpText;
    logic         oOutValid;
    logic         iOutReady;
    logic [127:0] oCpText;
    logic         oBusy;
`ifdef AES_ROUND_CTRL_BLKCNT_EN
    logic [15:0]  oBlkCnt;
`endif

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

    int checks = 0;
    int errors = 0;

    aes_round_ctrl dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iInValid       (iInValid),
        .oInReady       (oInReady),
        .iPlainText     (iPlainText),
        .iAesKey        (iAesKey),
        .oPlainText     (oPlainText),
        .oAesKey        (oAesKey),
        .oInitRoundFlag (oInitRoundFlag),
        .oFstRoundFlag  (oFstRoundFlag),
        .oMidRoundFlag  (oMidRoundFlag),
        .oLstRoundFlag  (oLstRoundFlag),
        .iRoundCpText   (iRoundCpText),
        .oOutValid      (oOutValid),
        .iOutReady      (iOutReady),
        .oCpText        (oCpText),
`ifdef AES_ROUND_CTRL_BLKCNT_EN
        .oBlkCnt        (oBlkCnt),
`endif
        .oBusy          (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq  = x;
        logic [7:0] inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] keyExp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0 = k[127:96];
        logic [31:0] w1 = k[95:64];
        logic [31:0] w2 = k[63:32];
        logic [31:0] w3 = k[31:0];
        logic [31:0] rw;
        logic [31:0] t;
        rw = {w3[23:0], w3[31:24]};
        t  = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] roundFn(input logic [127:0] st, input logic [127:0] rk,
                                             input logic doMix);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r+4*c] = a[r+4*((c+r)%4)];
        if (doMix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
        return res ^ rk;
    endfunction

    // Round function and key schedule stepped by the controller flags
    logic [127:0] rfState = '0;
    logic [127:0] rfKey   = '0;
    logic [7:0]   rfRcon  = 8'h01;

    always @(posedge iClk) begin
        if (oInitRoundFlag) begin
            rfState <= oPlainText ^ oAesKey;
            rfKey   <= oAesKey;
            rfRcon  <= 8'h01;
        end else if (oFstRoundFlag || oMidRoundFlag || oLstRoundFlag) begin
            rfState <= roundFn(rfState, keyExp(rfKey, rfRcon), !oLstRoundFlag);
            rfKey   <= keyExp(rfKey, rfRcon);
            rfRcon  <= xt(rfRcon);
        end
    end

    assign iRoundCpText = rfState;

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic acceptBlock(input logic [127:0] pt, input logic [127:0] key);
        iInValid   = 1'b1;
        iPlainText = pt;
        iAesKey    = key;
        @(posedge iClk);
        #1;
        iInValid   = 1'b0;
        iPlainText = ~pt;
        iAesKey    = ~key;
    endtask

    task automatic waitOut(output int lat, output int nI, output int nF, output int nM,
                           output int nL, output int bad);
        lat = 0; nI = 0; nF = 0; nM = 0; nL = 0; bad = 0;
        while (!oOutValid && lat < 30) begin
            nI += int'(oInitRoundFlag);
            nF += int'(oFstRoundFlag);
            nM += int'(oMidRoundFlag);
            nL += int'(oLstRoundFlag);
            if (int'(oInitRoundFlag) + int'(oFstRoundFlag) + int'(oMidRoundFlag) +
                int'(oLstRoundFlag) != 1) bad++;
            @(posedge iClk);
            #1;
            lat++;
        end
    endtask

    logic [3:0] flagsNow;
    assign flagsNow = {oInitRoundFlag, oFstRoundFlag, oMidRoundFlag, oLstRoundFlag};

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, nI, nF, nM, nL, bad;
        int outCyc [3];
        int nOut, cyc, idleSeen, spurious;

        iRst = 1'b1; iInValid = 1'b0; iOutReady = 1'b0;
        iPlainText = '0; iAesKey = '0;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        checkEq("rst_inReady", 128'(oInReady), 128'd1);
        checkEq("rst_busy",    128'(oBusy), 128'd0);
        checkEq("rst_flags",   128'(flagsNow), 128'd0);
        checkEq("rst_outValid", 128'(oOutValid), 128'd0);
        checkEq("rst_cpText",  oCpText, '0);
        checkEq("rst_pt",      oPlainText, '0);
        checkEq("rst_key",     oAesKey, '0);

        // FIPS-197 C.1 vector: latency, flag sequence, result
        acceptBlock(PT1, KEY1);
        checkEq("latch_pt",  oPlainText, PT1);
        checkEq("latch_key", oAesKey, KEY1);
        waitOut(lat, nI, nF, nM, nL, bad);
        checkEq("lat",      128'(lat), 128'd11);
        checkEq("n_init",   128'(nI), 128'd1);
        checkEq("n_fst",    128'(nF), 128'd1);
        checkEq("n_mid",    128'(nM), 128'd8);
        checkEq("n_lst",    128'(nL), 128'd1);
        checkEq("onehot",   128'(bad), 128'd0);
        checkEq("out_flags", 128'(flagsNow), 128'd0);
        checkEq("ct1",      oCpText, CT1);

        // Output stall with a competing input offer
        for (int k = 0; k < 5; k++) begin
            iInValid   = 1'b1;
            iPlainText = PT2;
            iAesKey    = KEY2;
            @(posedge iClk);
            #1;
            checkEq("stall_valid", 128'(oOutValid), 128'd1);
            checkEq("stall_ct",    oCpText, CT1);
            checkEq("stall_ready", 128'(oInReady), 128'd0);
        end
        checkEq("stall_pt_held", oPlainText, PT1);
        iInValid  = 1'b0;
        iOutReady = 1'b1;
        #1;
        checkEq("out_inReady", 128'(oInReady), 128'd1);
        @(posedge iClk);
        #1;
        iOutReady = 1'b0;
        checkEq("idle_busy",  128'(oBusy), 128'd0);
        checkEq("idle_valid", 128'(oOutValid), 128'd0);
        checkEq("idle_ct",    oCpText, '0);

        // Back-to-back blocks with both handshakes held high
        iInValid = 1'b1; iPlainText = PT1; iAesKey = KEY1; iOutReady = 1'b1;
        nOut = 0; cyc = 0; idleSeen = 0;
        while (nOut < 3 && cyc < 60) begin
            @(posedge iClk);
            #1;
            cyc++;
            if (!oBusy) idleSeen++;
            if (oOutValid) begin
                outCyc[nOut] = cyc;
                checkEq("b2b_ct", oCpText, CT1);
                nOut++;
                if (nOut == 3) iInValid = 1'b0;
            end
        end
        checkEq("b2b_count", 128'(nOut), 128'd3);
        checkEq("b2b_first", 128'(outCyc[0]), 128'd12);
        checkEq("b2b_gap1",  128'(outCyc[1] - outCyc[0]), 128'd12);
        checkEq("b2b_gap2",  128'(outCyc[2] - outCyc[1]), 128'd12);
        checkEq("b2b_noidle", 128'(idleSeen), 128'd0);
        @(posedge iClk);
        #1;
        iOutReady = 1'b0;
        checkEq("b2b_end_idle", 128'(oBusy), 128'd0);
`ifdef AES_ROUND_CTRL_BLKCNT_EN
        checkEq("blkcnt_4", 128'(oBlkCnt), 128'd4);
`endif

        // Asynchronous reset during the fifth middle round
        acceptBlock(PT1, KEY1);
        repeat (6) @(posedge iClk);
        #1;
        checkEq("pre_rst_mid", 128'(flagsNow), 128'b0010);
        #2;
        iRst = 1'b1;
        #1;
        checkEq("arst_flags",   128'(flagsNow), 128'd0);
        checkEq("arst_inReady", 128'(oInReady), 128'd1);
        checkEq("arst_busy",    128'(oBusy), 128'd0);
        checkEq("arst_valid",   128'(oOutValid), 128'd0);
        @(negedge iClk);
        iRst = 1'b0;
        spurious = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge iClk);
            #1;
            if (oOutValid || oBusy) spurious++;
        end
        checkEq("arst_quiet", 128'(spurious), 128'd0);

        // FIPS-197 B vector after the abort
        acceptBlock(PT2, KEY2);
        waitOut(lat, nI, nF, nM, nL, bad);
        checkEq("lat2", 128'(lat), 128'd11);
        checkEq("ct2",  oCpText, CT2);
        iOutReady = 1'b1;
        @(posedge iClk);
        #1;
        iOutReady = 1'b0;
        checkEq("end_idle", 128'(oBusy), 128'd0);

`ifdef AES_ROUND_CTRL_BLKCNT_EN
        checkEq("blkcnt_post_rst", 128'(oBlkCnt), 128'd1);
        force dut.blkCnt = 16'hFFFF;
        #1;
        release dut.blkCnt;
        acceptBlock(PT1, KEY1);
        waitOut(lat, nI, nF, nM, nL, bad);
        iOutReady = 1'b1;
        @(posedge iClk);
        #1;
        iOutReady = 1'b0;
        checkEq("blkcnt_sat", 128'(oBlkCnt), 128'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
